// File: rtl/exec_result_queue.sv
// exec_result_queue
//   Result buffer between one execution unit and the execute-output arbiter.
//   Finished results (value, commands, tag, flags) are held in strict FIFO
//   order until the arbiter grants this unit's slot. The execution unit can
//   keep issuing while the arbiter is busy serving other units.
//
// Optional build macro: EXEC_RESULT_QUEUE_BYPASS_EN
//   Adds a fall-through path. When the queue is empty, a push is shown on the
//   head outputs in the same cycle. If it is also granted in that cycle, it is
//   never written into the queue.
//
// Ports
//   clk_i, reset_i          clock; asynchronous active-high reset
//   push_i                  a result is presented this cycle
//   val_i/commands_i/
//   tag_i/flags_i           result payload
//   ready_o                 queue is not full
//   grant_i                 arbiter takes the head entry
//   flush_i                 synchronous discard of every entry
//   valid_o                 head entry is valid
//   val_o/commands_o/
//   tag_o/flags_o           head payload
//   count_o                 occupancy, 0..DEPTH
module exec_result_queue #(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize+1),
  parameter int DEPTH      = 4,
  parameter int DEPTHLog   = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [63:0]           val_i,
  input  logic [9:0]            commands_i,
  input  logic [ROBsizeLog-1:0] tag_i,
  input  logic [3:0]            flags_i,
  output logic                  ready_o,
  input  logic                  grant_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  output logic [63:0]           val_o,
  output logic [9:0]            commands_o,
  output logic [ROBsizeLog-1:0] tag_o,
  output logic [3:0]            flags_o,
  output logic [DEPTHLog:0]     count_o
);

  typedef struct packed {
    logic [63:0]           val;
    logic [9:0]            cmd;
    logic [ROBsizeLog-1:0] tag;
    logic [3:0]            flags;
  } entry_t;

  entry_t              mem [DEPTH];
  entry_t              in_ent, head;
  logic [DEPTHLog-1:0] rd_ptr, wr_ptr;
  logic [DEPTHLog:0]   count;
  logic                empty, full, push_acc, pop_acc, byp, byp_thru;

  assign in_ent   = '{val: val_i, cmd: commands_i, tag: tag_i, flags: flags_i};
  assign empty    = (count == '0);
  assign full     = (count == (DEPTHLog+1)'(DEPTH));
  // ready_o uses only registered state. It does not look ahead at grant_i,
  // so a push into a full queue is rejected even when a pop happens in the
  // same cycle.
  assign ready_o  = !full;

`ifdef EXEC_RESULT_QUEUE_BYPASS_EN
  assign byp      = empty && push_i && !flush_i;
  assign byp_thru = byp && grant_i;
`else
  assign byp      = 1'b0;
  assign byp_thru = 1'b0;
`endif

  // A result that passes straight through is consumed without being stored.
  assign push_acc = push_i && ready_o && !byp_thru;
  assign pop_acc  = grant_i && !empty;

  assign head       = byp ? in_ent : mem[rd_ptr];
  assign valid_o    = !empty || byp;
  assign val_o      = head.val;
  assign commands_o = head.cmd;
  assign tag_o      = head.tag;
  assign flags_o    = head.flags;
  assign count_o    = count;

  // Payload storage has no reset. The head fields are ignored while valid_o=0.
  always_ff @(posedge clk_i) begin
    if (push_acc && !flush_i) mem[wr_ptr] <= in_ent;
  end

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH by themselves.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_result_queue.sv
module tb_exec_result_queue;

  localparam int RSL = 6;

  logic           clk_i = 1'b0;
  logic           reset_i = 1'b1;
  logic           push_i = 1'b0, grant_i = 1'b0, flush_i = 1'b0;
  logic [63:0]    val_i = '0;
  logic [9:0]     commands_i = '0;
  logic [RSL-1:0] tag_i = '0;
  logic [3:0]     flags_i = '0;
  logic           ready_o, valid_o;
  logic [63:0]    val_o;
  logic [9:0]     commands_o;
  logic [RSL-1:0] tag_o;
  logic [3:0]     flags_o;
  logic [2:0]     count_o;

  int checks = 0, errors = 0;

  exec_result_queue dut (
    .clk_i(clk_i), .reset_i(reset_i), .push_i(push_i), .val_i(val_i),
    .commands_i(commands_i), .tag_i(tag_i), .flags_i(flags_i),
    .ready_o(ready_o), .grant_i(grant_i), .flush_i(flush_i),
    .valid_o(valid_o), .val_o(val_o), .commands_o(commands_o),
    .tag_o(tag_o), .flags_o(flags_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        push, grant, flush;
    logic [63:0] pval;
    logic        e_valid;
    int          e_count;
    logic [63:0] e_head;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [RSL-1:0] tag_of(logic [63:0] v);
    return (v == 64'hDEAD_BEEF) ? 6'd5 : v[5:0] ^ 6'h2A;
  endfunction
  function automatic logic [9:0] cmd_of(logic [63:0] v);
    return (v == 64'hDEAD_BEEF) ? 10'h3A : {v[4:0], ~v[4:0]};
  endfunction
  function automatic logic [3:0] flg_of(logic [63:0] v);
    return (v == 64'hDEAD_BEEF) ? 4'b1001 : v[3:0] + 4'd3;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(logic p, logic g, logic f, logic [63:0] pv,
                     logic ev, int ec, logic [63:0] eh);
    vec_t v;
    v.push = p; v.grant = g; v.flush = f; v.pval = pv;
    v.e_valid = ev; v.e_count = ec; v.e_head = eh;
    vecs.push_back(v);
  endtask

  task automatic drive(logic p, logic g, logic f, logic [63:0] pv);
    push_i = p; grant_i = g; flush_i = f; val_i = pv;
    tag_i = tag_of(pv); commands_i = cmd_of(pv); flags_i = flg_of(pv);
  endtask

  initial begin
    // Single pass
    add(1,0,0,64'hDEAD_BEEF, 1,1,64'hDEAD_BEEF);
    add(0,1,0,0,             0,0,0);
    // Fill and block
    add(1,0,0,1, 1,1,1);
    add(1,0,0,2, 1,2,1);
    add(1,0,0,3, 1,3,1);
    add(1,0,0,4, 1,4,1);
    add(1,0,0,5, 1,4,1);   // ignored while full
    add(0,1,0,0, 1,3,2);
    add(0,1,0,0, 1,2,3);
    add(0,1,0,0, 1,1,4);
    add(0,1,0,0, 0,0,0);
    // Wrap with simultaneous push and pop
    add(1,0,0,10, 1,1,10);
    add(1,0,0,11, 1,2,10);
    add(1,0,0,12, 1,3,10);
    for (int i = 0; i < 6; i++) add(1,1,0,13+i, 1,3,11+i);
    add(1,0,0,19, 1,4,16);
    add(1,1,0,20, 1,3,17); // full: pop only, 20 rejected
    // Flush priority
    add(0,1,0,0,  1,2,18);
    add(1,1,1,21, 0,0,0);
    add(1,0,0,22, 1,1,22);
    add(0,1,0,0,  0,0,0);

    // Reset state, then async reset mid-cycle with entries queued
    #2;
    chk("reset_valid", valid_o, 0);
    chk("reset_ready", ready_o, 1);
    chk("reset_count", count_o, 0);
    #10 reset_i = 1'b0;
    @(posedge clk_i); #1;
    drive(1,0,0,64'h77);
    @(posedge clk_i); #1;
    drive(1,0,0,64'h78);
    @(posedge clk_i); #1;
    drive(0,0,0,0);
    chk("prereset_count", count_o, 2);
    #2 reset_i = 1'b1;
    #1;
    chk("async_reset_valid", valid_o, 0);
    chk("async_reset_ready", ready_o, 1);
    chk("async_reset_count", count_o, 0);
    #1 reset_i = 1'b0;

    // Table
    @(posedge clk_i); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].push, vecs[i].grant, vecs[i].flush, vecs[i].pval);
      @(posedge clk_i); #1;
      chk($sformatf("v%0d_valid", i), valid_o, vecs[i].e_valid);
      chk($sformatf("v%0d_count", i), count_o, vecs[i].e_count);
      chk($sformatf("v%0d_ready", i), ready_o, vecs[i].e_count != 4);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_val", i), val_o, vecs[i].e_head);
        chk($sformatf("v%0d_tag", i), tag_o, tag_of(vecs[i].e_head));
        chk($sformatf("v%0d_cmd", i), commands_o, cmd_of(vecs[i].e_head));
        chk($sformatf("v%0d_flg", i), flags_o, flg_of(vecs[i].e_head));
      end
    end

    // Push with grant into an empty queue
    push_i = 1; grant_i = 1; flush_i = 0; val_i = 64'h99;
    tag_i = 6'd7; commands_i = 10'h155; flags_i = 4'h6;
    #1;
`ifdef EXEC_RESULT_QUEUE_BYPASS_EN
    chk("byp_valid_now", valid_o, 1);
    chk("byp_tag_now", tag_o, 7);
    chk("byp_val_now", val_o, 64'h99);
    @(posedge clk_i); #1;
    drive(0,0,0,0);
    chk("byp_count_after", count_o, 0);
    chk("byp_valid_after", valid_o, 0);
`else
    chk("nobyp_valid_now", valid_o, 0);
    @(posedge clk_i); #1;
    drive(0,0,0,0);
    chk("nobyp_valid_next", valid_o, 1);
    chk("nobyp_tag_next", tag_o, 7);
    chk("nobyp_count_next", count_o, 1);
    drive(0,1,0,0);
    @(posedge clk_i); #1;
    drive(0,0,0,0);
    chk("nobyp_drain", count_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
